// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single shared memory port arbitrated between loader, instruction and data masters
//
// Ports:
//   clk, rst_n                         clock; asynchronous active-low reset
//   ld_addr/ld_wdata/ld_we/ld_done     program-loader write port, owns the memory while ld_done=0
//   i_req/i_addr                       instruction fetch request (read only)
//   i_gnt/i_valid/i_err/i_rdata        instruction grant, response, error pulses and read data
//   d_req/d_addr/d_wdata/d_wstrb/d_we  data request (read or byte-strobed write)
//   d_gnt/d_ack/d_err/d_rdata          data grant, response, error pulses and read data
//   ext_addr/ext_wdata/ext_wstrb       registered shared-memory request
//   ext_we/ext_re
//   ext_rdata/ext_ready                shared-memory read data and completion
//   busy                               high whenever the arbiter is not IDLE (LOAD included)
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,   // 1..7: data grants in a row tolerated while fetch waits
  parameter int TIMEOUT      = 255  // >= 1: BUSY cycles without ext_ready before abort
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_we,
  input  logic        ld_done,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_valid,
  output logic        i_err,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_we,
  output logic        d_gnt,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,

  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wstrb,
  output logic        ext_we,
  output logic        ext_re,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ready,

  output logic        busy
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // The counter only needs to reach TIMEOUT-1: the abort fires on the edge
  // that would otherwise count the TIMEOUT-th stalled cycle.
  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [2:0]      STREAK_MAX = 3'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [2:0]    streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          owner_d_q, owner_d_d;   // 1: data master owns the transaction

  logic          i_gnt_d, i_valid_d, i_err_d;
  logic          d_gnt_d, d_ack_d, d_err_d;
  logic [31:0]   i_rdata_d, d_rdata_d;
  logic [31:0]   ext_addr_d, ext_wdata_d;
  logic [3:0]    ext_wstrb_d;
  logic          ext_we_d, ext_re_d;

  logic          pick_i;
  logic          zero_wr;

  // Instruction wins only when alone, or when data has used up its streak.
  assign pick_i  = i_req && (!d_req || (streak_q == STREAK_MAX));
  // A write with no enabled bytes has nothing to do on the memory side.
  assign zero_wr = d_we && (d_wstrb == 4'h0);

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    owner_d_d   = owner_d_q;
    ext_addr_d  = ext_addr;
    ext_wdata_d = ext_wdata;
    ext_wstrb_d = ext_wstrb;
    ext_we_d    = ext_we;
    ext_re_d    = ext_re;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    // Handshake outputs are single-cycle pulses unless re-armed below.
    i_gnt_d     = 1'b0;
    i_valid_d   = 1'b0;
    i_err_d     = 1'b0;
    d_gnt_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // Loader drives the memory directly; ext_ready is not consulted.
        ext_addr_d  = ld_addr;
        ext_wdata_d = ld_wdata;
        ext_wstrb_d = 4'hF;
        ext_we_d    = ld_we;
        ext_re_d    = 1'b0;
        if (ld_done) begin
          state_d  = ST_IDLE;
          ext_we_d = 1'b0;
        end
      end

      ST_IDLE: begin
        if (!ld_done) begin
          state_d = ST_LOAD;
        end else if (pick_i) begin
          state_d     = ST_BUSY;
          owner_d_d   = 1'b0;
          tmo_d       = '0;
          streak_d    = 3'd0;
          i_gnt_d     = 1'b1;
          ext_addr_d  = i_addr;
          ext_wdata_d = 32'h0;
          ext_wstrb_d = 4'h0;
          ext_we_d    = 1'b0;
          ext_re_d    = 1'b1;
        end else if (d_req) begin
          owner_d_d   = 1'b1;
          tmo_d       = '0;
          d_gnt_d     = 1'b1;
          ext_addr_d  = d_addr;
          ext_wdata_d = d_wdata;
          // Streak only grows while a fetch is actually waiting.
          if (!i_req) begin
            streak_d = 3'd0;
          end else if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + 3'd1;
          end
          if (zero_wr) begin
            // Nothing to access: skip BUSY, ack lands with the grant.
            state_d     = ST_RESP;
            ext_wstrb_d = 4'h0;
            ext_we_d    = 1'b0;
            ext_re_d    = 1'b0;
            d_ack_d     = 1'b1;
          end else if (d_we) begin
            state_d     = ST_BUSY;
            ext_wstrb_d = d_wstrb;
            ext_we_d    = 1'b1;
            ext_re_d    = 1'b0;
          end else begin
            state_d     = ST_BUSY;
            ext_wstrb_d = 4'h0;
            ext_we_d    = 1'b0;
            ext_re_d    = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        if (ext_ready) begin
          state_d  = ST_RESP;
          ext_we_d = 1'b0;
          ext_re_d = 1'b0;
          if (owner_d_q) begin
            d_rdata_d = ext_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = ext_rdata;
            i_valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abandon the access; the error pulse replaces the response and
          // the arbiter is immediately free again.
          state_d  = ST_IDLE;
          ext_we_d = 1'b0;
          ext_re_d = 1'b0;
          if (owner_d_q) begin
            d_rdata_d = 32'h0;
            d_err_d   = 1'b1;
          end else begin
            i_rdata_d = 32'h0;
            i_err_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      streak_q  <= 3'd0;
      tmo_q     <= '0;
      owner_d_q <= 1'b0;
      i_gnt     <= 1'b0;
      i_valid   <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= 32'h0;
      d_gnt     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'h0;
      ext_addr  <= 32'h0;
      ext_wdata <= 32'h0;
      ext_wstrb <= 4'h0;
      ext_we    <= 1'b0;
      ext_re    <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      tmo_q     <= tmo_d;
      owner_d_q <= owner_d_d;
      i_gnt     <= i_gnt_d;
      i_valid   <= i_valid_d;
      i_err     <= i_err_d;
      i_rdata   <= i_rdata_d;
      d_gnt     <= d_gnt_d;
      d_ack     <= d_ack_d;
      d_err     <= d_err_d;
      d_rdata   <= d_rdata_d;
      ext_addr  <= ext_addr_d;
      ext_wdata <= ext_wdata_d;
      ext_wstrb <= ext_wstrb_d;
      ext_we    <= ext_we_d;
      ext_re    <= ext_re_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_we, ld_done;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_valid, i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_we;
  logic        d_gnt, d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] ext_addr, ext_wdata;
  logic [3:0]  ext_wstrb;
  logic        ext_we, ext_re;
  logic [31:0] ext_rdata;
  logic        ext_ready;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_ref [8];
  logic [31:0] mem_ext [8];
  int          streak_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_we     (ld_we),
    .ld_done   (ld_done),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_valid   (i_valid),
    .i_err     (i_err),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_we      (d_we),
    .d_gnt     (d_gnt),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_wstrb (ext_wstrb),
    .ext_we    (ext_we),
    .ext_re    (ext_re),
    .ext_rdata (ext_rdata),
    .ext_ready (ext_ready),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0; ext_ready = 1'b0; ld_we = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    ld_done = 1'b1;
    tick();
    streak_m = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if ({i_gnt, i_valid, i_err, d_gnt, d_ack, d_err} !== 6'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000000", {i_gnt, i_valid, i_err, d_gnt, d_ack, d_err}); end
    checks++; if ({ext_we, ext_re, ext_wstrb} !== 6'b0) begin
      failures++; $display("FAIL reset_ext_ctl got=%b exp=000000", {ext_we, ext_re, ext_wstrb}); end
    checks++; if ({ext_addr, ext_wdata} !== 64'h0) begin
      failures++; $display("FAIL reset_ext_data got=%h exp=0", {ext_addr, ext_wdata}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata}); end
    repeat (3) tick();
  endtask

  task automatic test_loader();
    logic gnt_seen;
    ld_done = 1'b0; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEADBEEF;
    i_req = 1'b1; i_addr = 32'h100;
    rst_n = 1'b1;
    tick();
    checks++; if ({ext_we, ext_re, ext_wstrb, ext_addr, ext_wdata} !== {1'b1, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF}) begin
      failures++; $display("FAIL loader_write got we=%b re=%b strb=%h addr=%h data=%h exp we=1 re=0 strb=f addr=10 data=deadbeef",
                           ext_we, ext_re, ext_wstrb, ext_addr, ext_wdata); end
    gnt_seen = i_gnt;
    for (int k = 0; k < 4; k++) begin
      ld_addr = ld_addr + 32'h4;
      tick();
      gnt_seen = gnt_seen | i_gnt;
    end
    checks++; if (gnt_seen !== 1'b0) begin failures++; $display("FAIL loader_no_grant got=%b exp=0", gnt_seen); end
    checks++; if (ext_addr !== 32'h20) begin failures++; $display("FAIL loader_addr_track got=%h exp=20", ext_addr); end
    ld_we = 1'b0; ld_done = 1'b1;
    tick();
    checks++; if ({busy, ext_we, i_gnt} !== 3'b000) begin
      failures++; $display("FAIL loader_to_idle got busy/we/gnt=%b exp=000", {busy, ext_we, i_gnt}); end
    tick();
    checks++; if ({i_gnt, ext_re, ext_addr} !== {1'b1, 1'b1, 32'h100}) begin
      failures++; $display("FAIL first_fetch_grant got gnt=%b re=%b addr=%h exp gnt=1 re=1 addr=100", i_gnt, ext_re, ext_addr); end
    i_req = 1'b0; ext_ready = 1'b1; ext_rdata = 32'h0BADF00D;
    tick();
    checks++; if ({i_valid, i_rdata} !== {1'b1, 32'h0BADF00D}) begin
      failures++; $display("FAIL fetch_resp got valid=%b rdata=%h exp valid=1 rdata=0badf00d", i_valid, i_rdata); end
    ext_ready = 1'b0;
    tick();
  endtask

  task automatic test_read();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wstrb = 4'hF;
    ext_ready = 1'b1; ext_rdata = 32'h12345678;
    tick();
    checks++; if ({d_gnt, i_gnt, ext_re, ext_we, ext_wstrb, ext_addr, busy} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 1'b1}) begin
      failures++; $display("FAIL read_grant got dgnt=%b ignt=%b re=%b we=%b strb=%h addr=%h busy=%b exp 1 0 1 0 0 40 1",
                           d_gnt, i_gnt, ext_re, ext_we, ext_wstrb, ext_addr, busy); end
    d_req = 1'b0;
    tick();
    checks++; if ({d_ack, d_gnt, ext_re, d_rdata} !== {1'b1, 1'b0, 1'b0, 32'h12345678}) begin
      failures++; $display("FAIL read_ack got ack=%b gnt=%b re=%b rdata=%h exp 1 0 0 12345678", d_ack, d_gnt, ext_re, d_rdata); end
    ext_ready = 1'b0;
    tick();
    checks++; if ({busy, d_ack} !== 2'b00) begin failures++; $display("FAIL read_done got busy/ack=%b exp=00", {busy, d_ack}); end
  endtask

  task automatic test_starvation();
    string got, exp;
    int    s;
    logic  both;
    do_reset();
    got = ""; exp = ""; s = 0; both = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (s == STARVE_LIMIT) begin exp = {exp, "I"}; s = 0; end
      else begin exp = {exp, "D"}; s = s + 1; end
    end
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wstrb = 4'h0;
    ext_ready = 1'b1; ext_rdata = 32'h55AA55AA;
    for (int cyc = 0; cyc < 100 && got.len() < 10; cyc++) begin
      tick();
      if (i_gnt && d_gnt) both = 1'b1;
      if (d_gnt) got = {got, "D"};
      else if (i_gnt) got = {got, "I"};
    end
    checks++; if (got != exp) begin failures++; $display("FAIL starvation_order got=%s exp=%s", got, exp); end
    checks++; if (both !== 1'b0) begin failures++; $display("FAIL dual_grant got=%b exp=0", both); end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();
    ext_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [69:0] snap;
    int          bad;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; ext_ready = 1'b1; ext_rdata = 32'hCAFE0001;
    tick();
    d_req = 1'b0;
    tick();
    ext_ready = 1'b0;
    tick();
    checks++; if (d_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL pre_timeout_read got=%h exp=cafe0001", d_rdata); end
    d_req = 1'b1; d_addr = 32'h48;
    tick();
    checks++; if ({d_gnt, ext_re} !== 2'b11) begin failures++; $display("FAIL stall_grant got gnt/re=%b exp=11", {d_gnt, ext_re}); end
    snap = {ext_addr, ext_wdata, ext_wstrb, ext_we, ext_re};
    d_req = 1'b0;
    bad = 0;
    for (int k = 2; k <= TIMEOUT; k++) begin
      tick();
      if ({ext_addr, ext_wdata, ext_wstrb, ext_we, ext_re} !== snap || !busy || d_err || d_ack) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_stable got bad_cycles=%0d exp=0", bad); end
    tick();
    checks++; if ({d_err, d_ack, busy, ext_re, d_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL timeout_err got err=%b ack=%b busy=%b re=%b rdata=%h exp 1 0 0 0 0", d_err, d_ack, busy, ext_re, d_rdata); end
    tick();
    checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL timeout_err_pulse got=%b exp=0", d_err); end
  endtask

  task automatic test_zero_strobe();
    int   gnt_cyc, ack_cyc;
    logic acc_seen;
    gnt_cyc = -1; ack_cyc = -1; acc_seen = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'h0; d_addr = 32'h50; d_wdata = 32'h11112222;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (cyc == 0) d_req = 1'b0;
      if (d_gnt && gnt_cyc < 0) gnt_cyc = cyc;
      if (d_ack && ack_cyc < 0) ack_cyc = cyc;
      if (ext_we || ext_re) acc_seen = 1'b1;
    end
    checks++; if (gnt_cyc != 0) begin failures++; $display("FAIL zero_strobe_gnt got cycle=%0d exp=0", gnt_cyc); end
    checks++; if (ack_cyc != 0) begin failures++; $display("FAIL zero_strobe_ack got cycle=%0d exp=0", ack_cyc); end
    checks++; if (acc_seen !== 1'b0) begin failures++; $display("FAIL zero_strobe_no_access got=%b exp=0", acc_seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_strobe_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_busy();
    logic resp_seen;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 32'h60; d_wdata = 32'hA5A5A5A5; ext_ready = 1'b0;
    tick();
    checks++; if ({d_gnt, ext_we} !== 2'b11) begin failures++; $display("FAIL midreset_pre got gnt/we=%b exp=11", {d_gnt, ext_we}); end
    d_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ext_we, ext_re, ext_wstrb, ext_addr, ext_wdata, d_gnt, d_ack, d_err, busy} !== {6'b0, 64'h0, 4'b0001}) begin
      failures++; $display("FAIL midreset_async got we=%b re=%b strb=%h addr=%h data=%h gnt/ack/err/busy=%b exp all 0 busy=1",
                           ext_we, ext_re, ext_wstrb, ext_addr, ext_wdata, {d_gnt, d_ack, d_err, busy}); end
    tick();
    rst_n = 1'b1;
    ext_ready = 1'b1;
    resp_seen = 1'b0;
    repeat (5) begin
      tick();
      if (d_ack || d_err) resp_seen = 1'b1;
    end
    ext_ready = 1'b0;
    checks++; if (resp_seen !== 1'b0) begin failures++; $display("FAIL midreset_no_resp got=%b exp=0", resp_seen); end
  endtask

  task automatic test_random();
    logic        ir, dr, we, win_i, zw;
    int          sel, iidx, didx, delay, bad;
    logic [31:0] ia, da, dw, exp_rd, drv_rd;
    logic [3:0]  ds;
    logic [37:0] exp_ctl;
    logic [69:0] snap;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_ref[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      mem_ext[i] = mem_ref[i];
    end
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 3);
      ir   = (sel != 1);
      dr   = (sel != 0);
      iidx = $urandom_range(0, 7);
      didx = $urandom_range(0, 7);
      ia   = 32'(iidx) << 2;
      da   = 32'(didx) << 2;
      dw   = $urandom;
      ds   = 4'($urandom_range(0, 15));
      we   = 1'($urandom_range(0, 1));
      i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wdata = dw; d_wstrb = ds; d_we = we;

      win_i = ir && (!dr || streak_m == STARVE_LIMIT);
      if (win_i) streak_m = 0;
      else if (ir) streak_m = (streak_m < STARVE_LIMIT) ? streak_m + 1 : streak_m;
      else streak_m = 0;
      zw = !win_i && we && (ds == 4'h0);

      tick();
      i_req = 1'b0; d_req = 1'b0;
      checks++; if ({i_gnt, d_gnt} !== {win_i, !win_i}) begin
        failures++; $display("FAIL rnd_grant n=%0d got i/d=%b%b exp=%b%b", n, i_gnt, d_gnt, win_i, !win_i); end

      if (zw) begin
        checks++; if ({d_ack, ext_we, ext_re} !== 3'b100) begin
          failures++; $display("FAIL rnd_zero_strobe n=%0d got ack/we/re=%b exp=100", n, {d_ack, ext_we, ext_re}); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_zw_idle n=%0d got busy=%b exp=0", n, busy); end
      end else begin
        if (win_i)   exp_ctl = {ia, 1'b0, 1'b1, 4'h0};
        else if (we) exp_ctl = {da, 1'b1, 1'b0, ds};
        else         exp_ctl = {da, 1'b0, 1'b1, 4'h0};
        checks++; if ({ext_addr, ext_we, ext_re, ext_wstrb} !== exp_ctl) begin
          failures++; $display("FAIL rnd_ext n=%0d got addr=%h we=%b re=%b strb=%h exp=%h", n, ext_addr, ext_we, ext_re, ext_wstrb, exp_ctl); end
        if (!win_i && we) begin
          checks++; if (ext_wdata !== dw) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, ext_wdata, dw); end
        end
        snap  = {ext_addr, ext_wdata, ext_wstrb, ext_we, ext_re};
        delay = $urandom_range(0, 3);
        bad   = 0;
        ext_ready = 1'b0;
        for (int k = 0; k < delay; k++) begin
          tick();
          if ({ext_addr, ext_wdata, ext_wstrb, ext_we, ext_re} !== snap || i_gnt || d_gnt) bad++;
        end
        if (delay > 0) begin
          checks++; if (bad != 0) begin failures++; $display("FAIL rnd_stall n=%0d got bad_cycles=%0d exp=0", n, bad); end
        end
        // Bench-side memory responds from what the DUT actually put on ext_*.
        if (ext_we) mem_ext[ext_addr[4:2]] = merge(mem_ext[ext_addr[4:2]], ext_wdata, ext_wstrb);
        drv_rd = ext_re ? mem_ext[ext_addr[4:2]] : $urandom;
        ext_rdata = drv_rd;
        ext_ready = 1'b1;
        if (win_i) exp_rd = mem_ref[iidx];
        else if (we) begin
          mem_ref[didx] = merge(mem_ref[didx], dw, ds);
          exp_rd = drv_rd;
        end else exp_rd = mem_ref[didx];
        tick();
        ext_ready = 1'b0;
        if (win_i) begin
          checks++; if ({i_valid, d_ack, i_rdata} !== {1'b1, 1'b0, exp_rd}) begin
            failures++; $display("FAIL rnd_iresp n=%0d got valid=%b dack=%b rdata=%h exp 1 0 %h", n, i_valid, d_ack, i_rdata, exp_rd); end
        end else begin
          checks++; if ({d_ack, i_valid, d_rdata} !== {1'b1, 1'b0, exp_rd}) begin
            failures++; $display("FAIL rnd_dresp n=%0d got ack=%b ivalid=%b rdata=%h exp 1 0 %h", n, d_ack, i_valid, d_rdata, exp_rd); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_idle n=%0d got busy=%b exp=0", n, busy); end
      end
    end
  endtask

  initial begin
    ld_addr = 32'h0; ld_wdata = 32'h0; ld_we = 1'b0; ld_done = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0; d_we = 1'b0;
    ext_rdata = 32'h0; ext_ready = 1'b0;
    streak_m = 0;
    test_reset();
    test_loader();
    test_read();
    test_starvation();
    test_timeout();
    test_zero_strobe();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
